// File: rtl/pong_pkg.sv
// Shared definitions for the pong scoring logic: game states, seven-segment
// patterns and default game parameters.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_PLAYING   = 2'd0,
        ST_HOLD      = 2'd1,
        ST_GAME_OVER = 2'd2
    } state_t;

    // Bit 0 top, 1 upper-left, 2 upper-right, 3 middle, 4 lower-left, 5 lower-right, 6 bottom
    localparam logic [6:0] SEG_0     = 7'h77;
    localparam logic [6:0] SEG_1     = 7'h24;
    localparam logic [6:0] SEG_2     = 7'h5D;
    localparam logic [6:0] SEG_3     = 7'h6D;
    localparam logic [6:0] SEG_4     = 7'h2E;
    localparam logic [6:0] SEG_5     = 7'h6B;
    localparam logic [6:0] SEG_6     = 7'h7B;
    localparam logic [6:0] SEG_7     = 7'h25;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam int WIN_SCORE_DEF    = 9;
    localparam int HOLD_FRAMES_DEF  = 60;
    localparam int BLINK_FRAMES_DEF = 30;

endpackage

// File: rtl/seg7_encoder.sv
// Combinational 4-bit value to seven-segment pattern; values above 9 render blank.
module seg7_encoder
    import pong_pkg::*;
(
    input  logic [3:0] i_value,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_value)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/score_keeper.sv
// Pong score keeper: edge-detects point levels, tracks both scores, freezes play
// between points and blinks the winner's digit once the game is over.
module score_keeper
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = WIN_SCORE_DEF,
    parameter int HOLD_FRAMES  = HOLD_FRAMES_DEF,
    parameter int BLINK_FRAMES = BLINK_FRAMES_DEF
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_point_left,
    input  logic       i_point_right,
    input  logic       i_frame_tick,
    input  logic       i_new_game,
    output logic [6:0] o_digit_left,
    output logic [6:0] o_digit_right,
    output logic       o_freeze,
    output logic       o_game_over,
    output logic       o_winner,
    output logic [1:0] o_dbg_state
);

    localparam int CNT_MAX = (HOLD_FRAMES > BLINK_FRAMES) ? HOLD_FRAMES : BLINK_FRAMES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [3:0]    WIN        = 4'(WIN_SCORE);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_FRAMES - 1);
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_FRAMES - 1);

    state_t        state_q, state_d;
    logic [3:0]    left_q, left_d;
    logic [3:0]    right_q, right_d;
    logic          pl_q, pl_d;
    logic          pr_q, pr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          blink_q, blink_d;
    logic          winner_q, winner_d;
    logic [6:0]    dig_l_q, dig_l_d;
    logic [6:0]    dig_r_q, dig_r_d;
    logic          freeze_q, freeze_d;
    logic          go_q, go_d;

    logic          edge_l;
    logic          edge_r;
    logic [6:0]    seg_l;
    logic [6:0]    seg_r;

    seg7_encoder u_enc_left (
        .i_value (left_q),
        .o_seg   (seg_l)
    );

    seg7_encoder u_enc_right (
        .i_value (right_q),
        .o_seg   (seg_r)
    );

    always_comb begin
        edge_l   = i_point_left & ~pl_q;
        edge_r   = i_point_right & ~pr_q;
        pl_d     = i_point_left;
        pr_d     = i_point_right;
        state_d  = state_q;
        left_d   = left_q;
        right_d  = right_q;
        cnt_d    = cnt_q;
        blink_d  = blink_q;
        winner_d = winner_q;

        if (i_new_game) begin
            state_d = ST_HOLD;
            left_d  = 4'd0;
            right_d = 4'd0;
            cnt_d   = '0;
            blink_d = 1'b1;
        end else begin
            case (state_q)
                ST_PLAYING: begin
                    // Simultaneous edges still pause play, but nobody scores
                    if (edge_l || edge_r) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                        if (edge_l && !edge_r && left_q < WIN) begin
                            left_d = left_q + 4'd1;
                            if (left_q + 4'd1 == WIN) begin
                                state_d  = ST_GAME_OVER;
                                winner_d = 1'b0;
                                blink_d  = 1'b1;
                            end
                        end else if (edge_r && !edge_l && right_q < WIN) begin
                            right_d = right_q + 4'd1;
                            if (right_q + 4'd1 == WIN) begin
                                state_d  = ST_GAME_OVER;
                                winner_d = 1'b1;
                                blink_d  = 1'b1;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (i_frame_tick) begin
                        if (cnt_q == HOLD_LAST) begin
                            state_d = ST_PLAYING;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                ST_GAME_OVER: begin
                    if (i_frame_tick) begin
                        if (cnt_q == BLINK_LAST) begin
                            cnt_d   = '0;
                            blink_d = ~blink_q;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            endcase
        end

        freeze_d = (state_d != ST_PLAYING);
        go_d     = (state_d == ST_GAME_OVER);

        // Digits trail the score registers by one cycle; the blink blanks only the winner
        dig_l_d = seg_l;
        dig_r_d = seg_r;
        if (state_q == ST_GAME_OVER && !blink_q) begin
            if (winner_q) begin
                dig_r_d = SEG_BLANK;
            end else begin
                dig_l_d = SEG_BLANK;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= ST_HOLD;
            left_q   <= 4'd0;
            right_q  <= 4'd0;
            pl_q     <= 1'b0;
            pr_q     <= 1'b0;
            cnt_q    <= '0;
            blink_q  <= 1'b1;
            winner_q <= 1'b0;
            dig_l_q  <= SEG_0;
            dig_r_q  <= SEG_0;
            freeze_q <= 1'b1;
            go_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            left_q   <= left_d;
            right_q  <= right_d;
            pl_q     <= pl_d;
            pr_q     <= pr_d;
            cnt_q    <= cnt_d;
            blink_q  <= blink_d;
            winner_q <= winner_d;
            dig_l_q  <= dig_l_d;
            dig_r_q  <= dig_r_d;
            freeze_q <= freeze_d;
            go_q     <= go_d;
        end
    end

    assign o_digit_left  = dig_l_q;
    assign o_digit_right = dig_r_q;
    assign o_freeze      = freeze_q;
    assign o_game_over   = go_q;
    assign o_winner      = winner_q;
    assign o_dbg_state   = state_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: the driver queues expected output snapshots,
// a negedge monitor pops and compares them against the DUT.
module tb_score_keeper;
    import pong_pkg::*;

    localparam int W = 19;
    localparam logic [W-1:0] M_ALL   = {W{1'b1}};
    localparam logic [W-1:0] M_NOWIN = ~(19'd1 << 2);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       point_left = 1'b0;
    logic       point_right = 1'b0;
    logic       frame_tick = 1'b0;
    logic       new_game = 1'b0;
    logic [6:0] digit_left;
    logic [6:0] digit_right;
    logic       freeze;
    logic       game_over;
    logic       winner;
    logic [1:0] dbg_state;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mask_q[$];
    string        name_q[$];
    int           n_checks = 0;
    int           n_fail = 0;

    logic [6:0] seg_tab [0:9] = '{7'h77, 7'h24, 7'h5D, 7'h6D, 7'h2E,
                                  7'h6B, 7'h7B, 7'h25, 7'h7F, 7'h6F};

    always #5 clk = ~clk;

    score_keeper #(
        .WIN_SCORE    (9),
        .HOLD_FRAMES  (60),
        .BLINK_FRAMES (30)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_point_left  (point_left),
        .i_point_right (point_right),
        .i_frame_tick  (frame_tick),
        .i_new_game    (new_game),
        .o_digit_left  (digit_left),
        .o_digit_right (digit_right),
        .o_freeze      (freeze),
        .o_game_over   (game_over),
        .o_winner      (winner),
        .o_dbg_state   (dbg_state)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1 frame_tick = 1'b1;
            @(posedge clk);
            #1 frame_tick = 1'b0;
        end
    endtask

    task automatic pulse(input logic l, input logic r, input logic ng);
        cycle();
        point_left  = l;
        point_right = r;
        new_game    = ng;
        cycle();
        point_left  = 1'b0;
        point_right = 1'b0;
        new_game    = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [6:0] dl, input logic [6:0] dr,
                              input logic fr, input logic go, input logic win,
                              input logic [1:0] st, input logic [W-1:0] mask);
        exp_q.push_back({dl, dr, fr, go, win, st});
        mask_q.push_back(mask);
        name_q.push_back(name);
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [W-1:0] e;
        logic [W-1:0] m;
        logic [W-1:0] got;
        string        n;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                m   = mask_q.pop_front();
                n   = name_q.pop_front();
                got = {digit_left, digit_right, freeze, game_over, winner, dbg_state};
                n_checks++;
                if (((got ^ e) & m) != '0) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h (mask %h)", n, got, e, m);
                end
            end
        end
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        expect_out("reset_state", 7'h77, 7'h77, 1'b1, 1'b0, 1'b0, ST_HOLD, M_ALL);
        @(posedge clk);
        #1 rst = 1'b0;

        tick(59);
        expect_out("hold_59_ticks", 7'h77, 7'h77, 1'b1, 1'b0, 1'b0, ST_HOLD, M_ALL);
        tick(1);
        expect_out("hold_60_ticks", 7'h77, 7'h77, 1'b0, 1'b0, 1'b0, ST_PLAYING, M_ALL);

        // Left point held high: counts once, digit lags the score by a cycle
        cycle();
        point_left = 1'b1;
        cycle();
        expect_out("left_rise_plus1", 7'h77, 7'h77, 1'b1, 1'b0, 1'b0, ST_HOLD, M_ALL);
        cycle();
        expect_out("left_rise_plus2", 7'h24, 7'h77, 1'b1, 1'b0, 1'b0, ST_HOLD, M_ALL);
        repeat (96) cycle();
        expect_out("left_held", 7'h24, 7'h77, 1'b1, 1'b0, 1'b0, ST_HOLD, M_ALL);
        tick(60);
        expect_out("left_held_play", 7'h24, 7'h77, 1'b0, 1'b0, 1'b0, ST_PLAYING, M_ALL);
        repeat (4) cycle();
        expect_out("left_held_no_rescore", 7'h24, 7'h77, 1'b0, 1'b0, 1'b0, ST_PLAYING, M_ALL);
        point_left = 1'b0;

        pulse(1'b1, 1'b1, 1'b0);
        cycle();
        expect_out("both_edges", 7'h24, 7'h77, 1'b1, 1'b0, 1'b0, ST_HOLD, M_ALL);
        tick(60);
        expect_out("both_edges_play", 7'h24, 7'h77, 1'b0, 1'b0, 1'b0, ST_PLAYING, M_ALL);

        for (int i = 1; i <= 8; i++) begin
            pulse(1'b0, 1'b1, 1'b0);
            cycle();
            expect_out($sformatf("right_score_%0d", i), 7'h24, seg_tab[i],
                       1'b1, 1'b0, 1'b0, ST_HOLD, M_ALL);
            tick(60);
        end
        expect_out("right_8_play", 7'h24, 7'h7F, 1'b0, 1'b0, 1'b0, ST_PLAYING, M_ALL);

        pulse(1'b0, 1'b1, 1'b0);
        cycle();
        expect_out("right_wins", 7'h24, 7'h6F, 1'b1, 1'b1, 1'b1, ST_GAME_OVER, M_ALL);
        tick(29);
        expect_out("blink_visible_29", 7'h24, 7'h6F, 1'b1, 1'b1, 1'b1, ST_GAME_OVER, M_ALL);
        tick(1);
        cycle();
        expect_out("blink_blank_30", 7'h24, 7'h00, 1'b1, 1'b1, 1'b1, ST_GAME_OVER, M_ALL);
        tick(30);
        cycle();
        expect_out("blink_visible_60", 7'h24, 7'h6F, 1'b1, 1'b1, 1'b1, ST_GAME_OVER, M_ALL);
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        cycle();
        expect_out("game_over_ignores_points", 7'h24, 7'h6F, 1'b1, 1'b1, 1'b1, ST_GAME_OVER, M_ALL);

        pulse(1'b0, 1'b0, 1'b1);
        cycle();
        expect_out("new_game", 7'h77, 7'h77, 1'b1, 1'b0, 1'b0, ST_HOLD, M_NOWIN);
        tick(59);
        expect_out("new_game_hold_59", 7'h77, 7'h77, 1'b1, 1'b0, 1'b0, ST_HOLD, M_NOWIN);
        tick(1);
        expect_out("new_game_play", 7'h77, 7'h77, 1'b0, 1'b0, 1'b0, ST_PLAYING, M_NOWIN);

        pulse(1'b1, 1'b0, 1'b1);
        cycle();
        expect_out("new_game_beats_point", 7'h77, 7'h77, 1'b1, 1'b0, 1'b0, ST_HOLD, M_NOWIN);
        tick(60);
        expect_out("new_game_beats_point_play", 7'h77, 7'h77, 1'b0, 1'b0, 1'b0, ST_PLAYING, M_NOWIN);

        // A tick coinciding with the point edge is not counted toward the hold
        cycle();
        point_left = 1'b1;
        frame_tick = 1'b1;
        cycle();
        point_left = 1'b0;
        frame_tick = 1'b0;
        tick(59);
        expect_out("entry_tick_ignored", 7'h24, 7'h77, 1'b1, 1'b0, 1'b0, ST_HOLD, M_NOWIN);

        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (digit_left !== 7'h77) begin
            n_fail++;
            $display("FAIL async_reset_digit_left: got %h", digit_left);
        end
        n_checks++;
        if (digit_right !== 7'h77) begin
            n_fail++;
            $display("FAIL async_reset_digit_right: got %h", digit_right);
        end
        n_checks++;
        if (freeze !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset_freeze: got %b", freeze);
        end
        n_checks++;
        if (game_over !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_game_over: got %b", game_over);
        end
        n_checks++;
        if (winner !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_winner: got %b", winner);
        end
        expect_out("async_reset_mid_hold", 7'h77, 7'h77, 1'b1, 1'b0, 1'b0, ST_HOLD, M_ALL);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(59);
        expect_out("post_reset_hold_59", 7'h77, 7'h77, 1'b1, 1'b0, 1'b0, ST_HOLD, M_ALL);
        tick(1);
        expect_out("post_reset_play", 7'h77, 7'h77, 1'b0, 1'b0, 1'b0, ST_PLAYING, M_ALL);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drained: %0d expectations left unchecked", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
